// File: rtl/square_seq.sv
// Unsigned square of A by sequential shift-and-add (WIDTH add/shift steps, no multiplier).
// Latency: init accepted at edge k -> done/result valid between edges k+WIDTH+1 and k+WIDTH+2.
// Backpressure: none; init is ignored while busy and re-sampled once the block is idle again.
module square_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [WIDTH-1:0]     A,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The step counter alone ends RUN, so every operand takes the same time.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init) state_nxt = RUN;
            RUN:     if (count == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (init) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= A;
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                end
                // result only moves here, so it is stable through RUN and idle time.
                DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square_seq.sv
// Randomised and directed checks of square_seq against a plain a*a model with latency/pulse tracking.
module tb_square_seq;

    localparam int W   = 16;
    localparam int LAT = W + 1;
    localparam int GAP = W + 2;

    logic           clk  = 1'b0;
    logic           rst  = 1'b0;
    logic           init = 1'b0;
    logic [W-1:0]   A    = '0;
    logic [2*W-1:0] result;
    logic           done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;

    square_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .A      (A),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) n_done++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_sq(input logic [W-1:0] a);
        logic [63:0] p;
        p = 64'(a) * 64'(a);
        return p[2*W-1:0];
    endfunction

    // One operation: presync=1 means the caller already stands on a negedge.
    task automatic run_op(input logic [W-1:0] a, input int hold, input int mid,
                          input logic [W-1:0] a_mid, input bit presync, input string tag);
        int           t0;
        int           lat;
        int           d0;
        bit           changed;
        logic [2*W-1:0] r0;
        lat     = -1;
        changed = 1'b0;
        if (!presync) @(negedge clk);
        A    = a;
        init = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        r0 = result;
        d0 = n_done;
        for (int e = 1; e <= 3 * LAT; e++) begin
            @(negedge clk);
            if (e >= hold) init = 1'b0;
            if (e == mid) A = a_mid;
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc - t0;
                break;
            end
            if (result !== r0) changed = 1'b1;
        end
        chk({tag, " latency"}, 64'(lat), 64'(LAT));
        chk({tag, " result"}, 64'(result), 64'(ref_sq(a)));
        chk({tag, " result stable while busy"}, 64'(changed), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " done single cycle"}, 64'(done), 64'd0);
        chk({tag, " done pulse count"}, 64'(n_done - d0), 64'd1);
    endtask

    initial begin
        int          d0;
        int          t0;
        int          got[$];
        int          want[$];
        logic [W-1:0] ra;

        #2;
        chk("reset result", 64'(result), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // init held two cycles: one operation only
        run_op(16'h0021, 2, 0, '0, 1'b0, "a21");
        chk("a21 const", 64'(result), 64'h441);
        d0 = n_done;
        repeat (2 * LAT) @(posedge clk);
        #1;
        chk("a21 no second op", 64'(n_done - d0), 64'd0);

        run_op(16'hFFFF, 1, 0, '0, 1'b0, "ffff");
        chk("ffff const", 64'(result), 64'hFFFE0001);
        run_op(16'h0000, 1, 0, '0, 1'b0, "zero");
        run_op(16'h0001, 1, 0, '0, 1'b0, "one");

        // abort at RUN cycle 8
        @(negedge clk);
        A    = 16'h00FF;
        init = 1'b1;
        @(posedge clk);
        #1;
        d0 = n_done;
        @(negedge clk);
        init = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort result cleared", 64'(result), 64'd0);
        chk("abort done low", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(16'h0003, 1, 0, '0, 1'b1, "after abort");
        chk("after abort no stray done", 64'(n_done - d0), 64'd1);

        // A changes mid-operation and must not disturb it
        run_op(16'h0005, 1, 5, 16'h0007, 1'b0, "mid change");
        repeat (6) @(posedge clk);
        #1;
        chk("mid change held", 64'(result), 64'd25);

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            run_op(ra, 1, 0, '0, 1'b0, "rand");
        end

        // init held 40 cycles: back-to-back operations
        @(negedge clk);
        A    = 16'h0010;
        init = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int e = 2; e <= 80; e++) begin
            @(negedge clk);
            if (e > 40) init = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                got.push_back(cyc - t0);
                chk("b2b result", 64'(result), 64'h100);
            end
        end
        for (int acc_edge = 1; acc_edge <= 40; acc_edge += GAP)
            want.push_back(acc_edge + LAT - 1);
        chk("b2b pulse count", 64'(got.size()), 64'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            if (i < got.size())
                chk("b2b pulse edge", 64'(got[i]), 64'(want[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
